// File: rtl/acia_pkg.sv
// Shared definitions for the ACIA-style serial port: register addresses,
// control/status bit positions, the minimum usable divisor and the state
// type shared by the TX and RX frame sequencers.
package acia_pkg;

    localparam logic [1:0] ADDR_CTRL = 2'b00;  // W: control, R: status
    localparam logic [1:0] ADDR_DATA = 2'b01;  // W: TX push, R: RX pop
    localparam logic [1:0] ADDR_DIVL = 2'b10;  // divisor low byte
    localparam logic [1:0] ADDR_DIVH = 2'b11;  // divisor high bits

    localparam int CTRL_RX_IE    = 7;
    localparam int CTRL_TX_IE    = 6;
    localparam int CTRL_ERR_IE   = 5;
    localparam int CTRL_FLUSH_RX = 1;
    localparam int CTRL_FLUSH_TX = 0;

    localparam int STAT_IRQ      = 7;
    localparam int STAT_OVERRUN  = 6;
    localparam int STAT_FRAMING  = 5;
    localparam int STAT_TX_FULL  = 4;
    localparam int STAT_RX_FULL  = 3;
    localparam int STAT_TX_IDLE  = 2;
    localparam int STAT_TX_NFULL = 1;
    localparam int STAT_RX_NEMPTY = 0;

    localparam int MIN_DIV = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } uart_state_t;

endpackage

// File: rtl/acia_fifo_uart_if.sv
// CPU bus interface of the serial port.
//   cs   chip select, one access per cycle with cs=1
//   we   1 = write, 0 = read
//   addr register address (see acia_pkg)
//   din  write data
//   dout registered read data
interface acia_fifo_uart_if;
    logic       cs;
    logic       we;
    logic [1:0] addr;
    logic [7:0] din;
    logic [7:0] dout;

    modport master (output cs, we, addr, din, input dout);
    modport slave  (input cs, we, addr, din, output dout);
endinterface

// File: rtl/acia_sfifo.sv
// Synchronous FIFO with first-word fall-through read port.
//   clk, rst_n  clock, asynchronous active-low reset
//   push, din   write an entry (ignored when full unless a pop happens too)
//   pop         drop the head entry (ignored when empty)
//   flush       empty the FIFO; overrides push and pop
//   dout        current head entry
//   full, empty, count  occupancy (count is log2(DEPTH)+1 bits)
module acia_sfifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop & ~empty;
    // A push into a full FIFO is still accepted when the head leaves on the same edge.
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !flush)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/acia_fifo_uart.sv
// CPU-bus 8N1 serial port with TX/RX FIFOs, run-time divisor, maskable irq
// and sticky error flags.
//   clk    system clock
//   rst_n  asynchronous reset, active low
//   bus    CPU register interface (slave side)
//   rx     asynchronous serial input, idle high
//   tx     serial output, idle high
//   irq    level interrupt request, active high
module acia_fifo_uart
    import acia_pkg::*;
#(
    parameter int CLK_FREQ = 32768,
    parameter int DEF_BAUD = 1024,
    parameter int DIV_W    = 16,
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    acia_fifo_uart_if.slave         bus,
    input  logic                    rx,
    output logic                    tx,
    output logic                    irq
);
    localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(CLK_FREQ / DEF_BAUD);
    localparam int TAW = $clog2(TX_DEPTH);
    localparam int RAW = $clog2(RX_DEPTH);

    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
        return (d < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : d;
    endfunction

    // Bus decode
    logic wr_ctrl, wr_data, wr_divl, wr_divh, rd_stat, rd_data;
    assign wr_ctrl = bus.cs &  bus.we & (bus.addr == ADDR_CTRL);
    assign wr_data = bus.cs &  bus.we & (bus.addr == ADDR_DATA);
    assign wr_divl = bus.cs &  bus.we & (bus.addr == ADDR_DIVL);
    assign wr_divh = bus.cs &  bus.we & (bus.addr == ADDR_DIVH);
    assign rd_stat = bus.cs & ~bus.we & (bus.addr == ADDR_CTRL);
    assign rd_data = bus.cs & ~bus.we & (bus.addr == ADDR_DATA);

    logic tx_flush, rx_flush;
    assign tx_flush = wr_ctrl & bus.din[CTRL_FLUSH_TX];
    assign rx_flush = wr_ctrl & bus.din[CTRL_FLUSH_RX];

    logic             rx_ie, tx_ie, err_ie, ovr_q, ferr_q;
    logic [DIV_W-1:0] div_q;
    logic [7:0]       dout_q, rd_mux, status;
    logic             rx_push, rx_ovr_set, rx_ferr_set;

    // FIFOs
    logic           tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0]     tx_head;
    logic [TAW:0]   tx_count;
    logic           rx_pop, rx_full, rx_empty;
    logic [7:0]     rx_head, rx_shift;
    logic [RAW:0]   rx_count;
    logic           rx_count_unused;

    assign tx_push = wr_data & ~tx_full;          // byte dropped silently when full
    assign rx_pop  = rd_data & ~rx_empty;
    assign rx_count_unused = ^rx_count;

    acia_sfifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk(clk), .rst_n(rst_n), .push(tx_push), .pop(tx_pop), .flush(tx_flush),
        .din(bus.din), .dout(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count)
    );

    acia_sfifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk(clk), .rst_n(rst_n), .push(rx_push), .pop(rx_pop), .flush(rx_flush),
        .din(rx_shift), .dout(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
    );

    // TX sequencer
    uart_state_t      tx_state, tx_state_n;
    logic [DIV_W-1:0] tx_div, tx_div_n, tx_cnt, tx_cnt_n;
    logic [2:0]       tx_bit, tx_bit_n;
    logic [7:0]       tx_shift, tx_shift_n;
    logic             tx_bit_end, tx_idle;

    assign tx_bit_end = (tx_cnt == tx_div - 1'b1);
    assign tx_idle    = (tx_count == '0) & (tx_state == S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= S_IDLE;
            tx_div   <= RST_DIV;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
        end else begin
            tx_state <= tx_state_n;
            tx_div   <= tx_div_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            tx_shift <= tx_shift_n;
        end
    end

    always_comb begin
        tx_state_n = tx_state;
        tx_div_n   = tx_div;
        tx_cnt_n   = tx_cnt + 1'b1;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        tx_pop     = 1'b0;
        case (tx_state)
            S_IDLE: begin
                tx_cnt_n = '0;
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_n = tx_head;
                    tx_div_n   = clamp_div(div_q);
                    tx_state_n = S_START;
                end
            end
            S_START: if (tx_bit_end) begin
                tx_cnt_n   = '0;
                tx_bit_n   = '0;
                tx_state_n = S_DATA;
            end
            S_DATA: if (tx_bit_end) begin
                tx_cnt_n   = '0;
                tx_shift_n = {1'b0, tx_shift[7:1]};
                tx_bit_n   = tx_bit + 1'b1;
                if (tx_bit == 3'd7)
                    tx_state_n = S_STOP;
            end
            S_STOP: if (tx_bit_end) begin
                tx_cnt_n = '0;
                // Chain straight into the next start bit so frames abut.
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_n = tx_head;
                    tx_div_n   = clamp_div(div_q);
                    tx_state_n = S_START;
                end else begin
                    tx_state_n = S_IDLE;
                end
            end
            default: tx_state_n = S_IDLE;
        endcase
        if (tx_flush) begin
            tx_state_n = S_IDLE;
            tx_cnt_n   = '0;
            tx_pop     = 1'b0;
        end
    end

    // Decoded from state so reset drives the line high without waiting for a clock.
    assign tx = (tx_state == S_START) ? 1'b0 :
                (tx_state == S_DATA)  ? tx_shift[0] : 1'b1;

    // RX synchronizer and sequencer
    logic rx_s1, rx_s2, rx_prev, rx_fall;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end
    // Starting only on a falling edge means a frame that ended with a low stop
    // bit cannot restart until the line has gone high again.
    assign rx_fall = rx_prev & ~rx_s2;

    uart_state_t      rx_state, rx_state_n;
    logic [DIV_W-1:0] rx_div, rx_div_n, rx_cnt, rx_cnt_n;
    logic [2:0]       rx_bit, rx_bit_n;
    logic [7:0]       rx_shift_n;
    logic             rx_bit_end, rx_half;

    assign rx_bit_end = (rx_cnt == rx_div - 1'b1);
    assign rx_half    = (rx_cnt == (rx_div >> 1) - 1'b1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= S_IDLE;
            rx_div   <= RST_DIV;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_state <= rx_state_n;
            rx_div   <= rx_div_n;
            rx_cnt   <= rx_cnt_n;
            rx_bit   <= rx_bit_n;
            rx_shift <= rx_shift_n;
        end
    end

    always_comb begin
        rx_state_n  = rx_state;
        rx_div_n    = rx_div;
        rx_cnt_n    = rx_cnt + 1'b1;
        rx_bit_n    = rx_bit;
        rx_shift_n  = rx_shift;
        rx_push     = 1'b0;
        rx_ovr_set  = 1'b0;
        rx_ferr_set = 1'b0;
        case (rx_state)
            S_IDLE: begin
                rx_cnt_n = '0;
                if (rx_fall) begin
                    rx_div_n   = clamp_div(div_q);
                    rx_state_n = S_START;
                end
            end
            S_START: if (rx_half) begin
                rx_cnt_n   = '0;
                rx_bit_n   = '0;
                rx_state_n = rx_s2 ? S_IDLE : S_DATA;  // high at mid-start: glitch
            end
            S_DATA: if (rx_bit_end) begin
                rx_cnt_n   = '0;
                rx_shift_n = {rx_s2, rx_shift[7:1]};
                rx_bit_n   = rx_bit + 1'b1;
                if (rx_bit == 3'd7)
                    rx_state_n = S_STOP;
            end
            S_STOP: if (rx_bit_end) begin
                rx_cnt_n   = '0;
                rx_state_n = S_IDLE;
                if (!rx_s2)
                    rx_ferr_set = 1'b1;
                else if (!rx_full || rx_pop)
                    rx_push = 1'b1;
                else
                    rx_ovr_set = 1'b1;
            end
            default: rx_state_n = S_IDLE;
        endcase
    end

    // Register file and read path
    assign status = {irq, ovr_q, ferr_q, tx_full, rx_full, tx_idle, ~tx_full, ~rx_empty};

    always_comb begin
        rd_mux = 8'h00;
        case (bus.addr)
            ADDR_CTRL: rd_mux = status;
            ADDR_DATA: rd_mux = rx_empty ? 8'h00 : rx_head;
            ADDR_DIVL: rd_mux = div_q[7:0];
            ADDR_DIVH: rd_mux = 8'(div_q[DIV_W-1:8]);
            default:   rd_mux = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= 8'h00;
            rx_ie  <= 1'b0;
            tx_ie  <= 1'b0;
            err_ie <= 1'b0;
            ovr_q  <= 1'b0;
            ferr_q <= 1'b0;
            div_q  <= RST_DIV;
        end else begin
            if (wr_ctrl)
                {rx_ie, tx_ie, err_ie} <= bus.din[7:5];
            if (wr_divl)
                div_q[7:0] <= bus.din;
            if (wr_divh)
                div_q[DIV_W-1:8] <= (DIV_W-8)'(bus.din);
            // Status read clears the sticky flags; a new error on the same edge wins.
            if (rd_stat) begin
                ovr_q  <= 1'b0;
                ferr_q <= 1'b0;
            end
            if (rx_ovr_set)
                ovr_q <= 1'b1;
            if (rx_ferr_set)
                ferr_q <= 1'b1;
            if (bus.cs && !bus.we)
                dout_q <= rd_mux;
        end
    end

    assign bus.dout = dout_q;
    assign irq = (rx_ie & ~rx_empty) | (tx_ie & tx_empty) | (err_ie & (ovr_q | ferr_q));

endmodule

// File: tb/tb_acia_fifo_uart.sv
module tb_acia_fifo_uart;
    import acia_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx_line = 1'b1;
    logic tx, irq;

    acia_fifo_uart_if bus();

    acia_fifo_uart #(
        .CLK_FREQ(32768), .DEF_BAUD(1024), .DIV_W(16), .TX_DEPTH(16), .RX_DEPTH(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .rx(rx_line), .tx(tx), .irq(irq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model of the register-visible state
    bit         m_rx_ie, m_tx_ie, m_err_ie, m_ovr, m_ferr;
    logic [7:0] rx_q[$];

    function automatic logic [7:0] exp_status(input bit tx_empty, input bit tx_full, input bit tx_idle);
        bit rxne = (rx_q.size() > 0);
        bit rxf  = (rx_q.size() == 16);
        bit irqm = (m_rx_ie && rxne) || (m_tx_ie && tx_empty) || (m_err_ie && (m_ovr || m_ferr));
        return {irqm, m_ovr, m_ferr, tx_full, rxf, tx_idle, !tx_full, rxne};
    endfunction

    function automatic bit exp_irq_idle();
        return (m_rx_ie && rx_q.size() > 0) || m_tx_ie || (m_err_ie && (m_ovr || m_ferr));
    endfunction

    // Bus tasks: called at a negedge, return at the following negedge
    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        bus.cs = 1'b1; bus.we = 1'b1; bus.addr = a; bus.din = d;
        @(negedge clk);
        bus.cs = 1'b0; bus.we = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        bus.cs = 1'b1; bus.we = 1'b0; bus.addr = a;
        @(negedge clk);
        bus.cs = 1'b0;
        d = bus.dout;
    endtask

    task automatic write_ctrl(input logic [7:0] v);
        bus_write(ADDR_CTRL, v);
        m_rx_ie = v[7]; m_tx_ie = v[6]; m_err_ie = v[5];
    endtask

    task automatic set_div(input logic [15:0] d);
        bus_write(ADDR_DIVL, d[7:0]);
        bus_write(ADDR_DIVH, d[15:8]);
    endtask

    // Status read with TX assumed idle and empty
    task automatic status_idle(input string tag);
        logic [7:0] d;
        bus_read(ADDR_CTRL, d);
        check(tag, 32'(d), 32'(exp_status(1'b1, 1'b0, 1'b1)));
        m_ovr = 1'b0; m_ferr = 1'b0;
    endtask

    task automatic read_data(input string tag);
        logic [7:0] d, e;
        bus_read(ADDR_DATA, d);
        e = (rx_q.size() > 0) ? rx_q.pop_front() : 8'h00;
        check(tag, 32'(d), 32'(e));
    endtask

    // Serial line driver; the model is updated with what a correct receiver keeps
    task automatic send_rx(input logic [7:0] b, input logic stopb, input int d);
        rx_line = 1'b0;
        repeat (d) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_line = b[i];
            repeat (d) @(negedge clk);
        end
        rx_line = stopb;
        repeat (d) @(negedge clk);
        rx_line = 1'b1;
        if (!stopb)
            m_ferr = 1'b1;
        else if (rx_q.size() < 16)
            rx_q.push_back(b);
        else
            m_ovr = 1'b1;
    endtask

    // TX line monitor: decodes frames at the bit length mon_div
    int         mon_div = 32;
    bit         mon_en = 1'b1;
    logic [7:0] mon_b[$];
    int         mon_t[$];
    logic       mon_ok[$];
    int         mon_st;
    logic [7:0] mon_byte;
    logic       mon_good;

    always begin
        @(negedge clk);
        if (mon_en && rst_n && tx === 1'b0) begin
            mon_st = cyc;
            repeat (mon_div / 2) @(negedge clk);
            mon_good = (tx === 1'b0);
            for (int i = 0; i < 8; i++) begin
                repeat (mon_div) @(negedge clk);
                mon_byte[i] = tx;
            end
            repeat (mon_div) @(negedge clk);
            mon_good = mon_good & (tx === 1'b1);
            mon_b.push_back(mon_byte);
            mon_t.push_back(mon_st);
            mon_ok.push_back(mon_good);
        end
    end

    task automatic mon_clear();
        mon_b.delete(); mon_t.delete(); mon_ok.delete();
    endtask

    task automatic wait_frames(input string tag, input int n, input int budget);
        int w = 0;
        while (mon_b.size() < n && w < budget) begin
            @(negedge clk);
            w++;
        end
        check(tag, 32'(mon_b.size()), 32'(n));
    endtask

    initial begin
        logic [7:0] d, b;
        logic [7:0] exp_tx[$];
        logic [7:0] wave;
        int w, errs;
        bit e;

        bus.cs = 1'b0; bus.we = 1'b0; bus.addr = 2'b00; bus.din = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'(1));
        check("rst_irq", 32'(irq), 32'(0));
        check("rst_dout", 32'(bus.dout), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state through the register file
        status_idle("status_after_reset");
        bus_read(ADDR_DIVL, d);
        check("div_reset", 32'(d), 32'(32));

        // Single frame at the default divisor, checked cycle by cycle
        wave = 8'h55;
        mon_clear();
        bus_write(ADDR_DATA, wave);
        w = 0;
        while (tx !== 1'b0 && w < 3) begin
            @(negedge clk);
            w++;
        end
        check("tx_start_latency", 32'(tx === 1'b0 && w <= 2), 32'(1));
        errs = 0;
        for (int c = 0; c < 330; c++) begin
            e = (c < 32) ? 1'b0 : (c < 288) ? wave[c / 32 - 1] : 1'b1;
            if (tx !== e) errs++;
            @(negedge clk);
        end
        check("tx_55_waveform", 32'(errs), 32'(0));
        check("tx_55_monitor", 32'(mon_b.size() > 0 ? mon_b[0] : 8'hxx), 32'(8'h55));

        // Burst of 17 frames at divisor 8, FIFO full, 18th byte dropped
        set_div(16'd8);
        mon_div = 8;
        mon_clear();
        exp_tx.delete();
        for (int i = 0; i < 17; i++) begin
            b = 8'($urandom);
            exp_tx.push_back(b);
            bus_write(ADDR_DATA, b);
        end
        bus_read(ADDR_CTRL, d);
        check("tx_full_status", 32'(d), 32'(exp_status(1'b0, 1'b1, 1'b0)));
        bus_write(ADDR_DATA, 8'($urandom));
        wait_frames("tx_burst_frames", 17, 17 * 80 + 100);
        repeat (200) @(negedge clk);
        check("tx_burst_no_extra", 32'(mon_b.size()), 32'(17));
        errs = 0;
        for (int i = 0; i < 17 && i < mon_b.size(); i++) begin
            if (mon_b[i] !== exp_tx[i] || mon_ok[i] !== 1'b1) errs++;
            if (i > 0 && mon_t[i] - mon_t[i-1] != 80) errs++;
        end
        check("tx_burst_content_timing", 32'(errs), 32'(0));
        status_idle("tx_idle_after_burst");
        write_ctrl(8'h40);
        check("irq_tx_empty", 32'(irq), 32'(exp_irq_idle()));
        write_ctrl(8'h00);
        check("irq_off", 32'(irq), 32'(0));

        // Divisor below the minimum is clamped to 4
        set_div(16'd2);
        mon_div = 4;
        mon_clear();
        b = 8'($urandom);
        bus_write(ADDR_DATA, b);
        wait_frames("tx_clamp_frame", 1, 200);
        check("tx_clamp_byte", 32'(mon_b.size() > 0 ? {mon_ok[0], mon_b[0]} : 9'h0), 32'({1'b1, b}));
        repeat (20) @(negedge clk);
        set_div(16'd32);
        mon_div = 32;

        // TX flush stops the frame in flight and discards queued bytes
        mon_en = 1'b0;
        bus_write(ADDR_DATA, 8'h00);
        bus_write(ADDR_DATA, 8'h00);
        bus_write(ADDR_DATA, 8'h00);
        repeat (50) @(negedge clk);
        check("tx_low_before_flush", 32'(tx), 32'(0));
        write_ctrl(8'h01);
        check("tx_high_after_flush", 32'(tx), 32'(1));
        status_idle("status_after_flush");
        errs = 0;
        for (int c = 0; c < 400; c++) begin
            if (tx !== 1'b1) errs++;
            @(negedge clk);
        end
        check("tx_quiet_after_flush", 32'(errs), 32'(0));
        mon_en = 1'b1;

        // Receive one byte, read it, then read the empty FIFO
        send_rx(8'hA3, 1'b1, 32);
        repeat (5) @(negedge clk);
        status_idle("rx_status_one");
        read_data("rx_byte_a3");
        read_data("rx_empty_read");
        status_idle("rx_status_empty");

        // RX interrupt follows FIFO occupancy
        write_ctrl(8'h80);
        send_rx(8'($urandom), 1'b1, 32);
        repeat (5) @(negedge clk);
        check("irq_rx", 32'(irq), 32'(exp_irq_idle()));
        read_data("rx_byte_irq");
        check("irq_rx_cleared", 32'(irq), 32'(exp_irq_idle()));
        write_ctrl(8'h00);

        // Overrun: 17 frames, no reads
        for (int i = 0; i < 17; i++)
            send_rx(8'($urandom), 1'b1, 32);
        repeat (5) @(negedge clk);
        status_idle("rx_overrun_status");
        status_idle("rx_overrun_cleared");
        for (int i = 0; i < 16; i++)
            read_data("rx_fifo_order");
        status_idle("rx_drained");

        // Framing error: flag set, nothing pushed, err_ie raises irq
        send_rx(8'($urandom), 1'b0, 32);
        repeat (40) @(negedge clk);
        write_ctrl(8'h20);
        check("irq_framing", 32'(irq), 32'(exp_irq_idle()));
        status_idle("rx_framing_status");
        check("irq_framing_cleared", 32'(irq), 32'(exp_irq_idle()));
        read_data("rx_framing_no_push");
        write_ctrl(8'h00);

        // Short low glitch is rejected; a following real frame still arrives
        rx_line = 1'b0;
        repeat (10) @(negedge clk);
        rx_line = 1'b1;
        repeat (100) @(negedge clk);
        status_idle("rx_glitch_status");
        send_rx(8'($urandom), 1'b1, 32);
        repeat (5) @(negedge clk);
        read_data("rx_after_glitch");

        // Asynchronous reset in the middle of a frame
        mon_en = 1'b0;
        set_div(16'd16);
        bus_write(ADDR_DATA, 8'h00);
        repeat (30) @(negedge clk);
        check("tx_low_before_reset", 32'(tx), 32'(0));
        #2 rst_n = 1'b0;
        #1;
        check("tx_async_reset", 32'(tx), 32'(1));
        check("irq_async_reset", 32'(irq), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        m_rx_ie = 0; m_tx_ie = 0; m_err_ie = 0; m_ovr = 0; m_ferr = 0;
        rx_q.delete();
        @(negedge clk);
        status_idle("status_after_midframe_reset");
        bus_read(ADDR_DIVL, d);
        check("div_after_midframe_reset", 32'(d), 32'(32));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
